dmem_arbiter: RTL and testbench

Shares the single-port data memory between the CPU data port and a secondary bus master (DMA/debug loader). The arbiter accepts word requests from either master through a req/ack handshake, translates byte addresses from the data segment (base 0x10010000) into an 11-bit word index, and performs one access per grant. It sits between the CPU and dmem in the top-level dataflow, replacing the direct address subtraction and slicing done there.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_addr_xlate.sv | 28 ++
 rtl/dmem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter and its address translator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_arb_pkg;

    // Byte address of dmem word 0 and the width of the word index (2048 words).
    localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;
    localparam int          DMEM_AW        = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DMA = 1'b1
    } gnt_id_t;

endpackage

// File: rtl/dmem_addr_xlate.sv
// Byte address to dmem word index translation for any dmem master.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   byte_addr  in   32  byte address in the data segment
//   addr_ok    out  1   address is word aligned and inside the dmem window
//   word_idx   out  AW  word index, meaningful only when addr_ok
module dmem_addr_xlate
    import dmem_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DMEM_BASE_ADDR,
    parameter int          AW        = DMEM_AW
) (
    input  logic [31:0]   byte_addr,
    output logic          addr_ok,
    output logic [AW-1:0] word_idx
);

    logic [31:0] offset;

    // Modulo-2^32 subtraction: addresses below the base wrap to a huge offset,
    // so the upper-bits check rejects them along with addresses past the window.
    assign offset   = byte_addr - BASE_ADDR;
    assign addr_ok  = (offset[31:AW+2] == '0) && (offset[1:0] == 2'b00);
    assign word_idx = offset[AW+1:2];

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem between the CPU data port and a secondary (DMA/debug) master.
// Latency: request sampled in IDLE -> one ACCESS cycle -> one-cycle ack in RESP (3 cycles per access).
// Backpressure: req held until ack; a losing request simply stays pending and is served next.
//
// Ports:
//   clk_in, reset                 clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata         CPU request, held stable until cpu_ack
//   cpu_rdata/ack/err             CPU response; rdata/err hold until the next CPU ack
//   dma_*                         same set for the secondary master
//   mem_wena/rena/addr/wdata      dmem controls, nonzero only in ACCESS
//   mem_rdata                     dmem read data, combinational from mem_addr
//
// Build option: DMEM_ARB_RR_EN selects round-robin on ties; otherwise the CPU always wins ties.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DMEM_BASE_ADDR,
    parameter int          AW        = DMEM_AW
) (
    input  logic          clk_in,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_err,

    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [31:0]   dma_addr,
    input  logic [31:0]   dma_wdata,
    output logic [31:0]   dma_rdata,
    output logic          dma_ack,
    output logic          dma_err,

    output logic          mem_wena,
    output logic          mem_rena,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    arb_state_t    state_q, state_d;
    gnt_id_t       gnt_q, gnt_sel;
    logic          any_req;
    logic          lat_we;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic          addr_ok;
    logic [AW-1:0] word_idx;
    logic [31:0]   cpu_rdata_q, dma_rdata_q;
    logic          cpu_err_q, dma_err_q;

    assign any_req = cpu_req | dma_req;

    dmem_addr_xlate #(
        .BASE_ADDR (BASE_ADDR),
        .AW        (AW)
    ) u_xlate (
        .byte_addr (lat_addr),
        .addr_ok   (addr_ok),
        .word_idx  (word_idx)
    );

`ifdef DMEM_ARB_RR_EN
    gnt_id_t last_gnt_q;

    // On a tie the master that was not granted last wins.
    always_comb begin
        gnt_sel = GNT_CPU;
        if (cpu_req && dma_req) begin
            gnt_sel = (last_gnt_q == GNT_CPU) ? GNT_DMA : GNT_CPU;
        end else if (dma_req) begin
            gnt_sel = GNT_DMA;
        end
    end

    // Reset to DMA so the CPU wins the first tie.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            last_gnt_q <= GNT_DMA;
        end else if (state_q == IDLE && any_req) begin
            last_gnt_q <= gnt_sel;
        end
    end
`else
    always_comb begin
        gnt_sel = GNT_DMA;
        if (cpu_req) begin
            gnt_sel = GNT_CPU;
        end
    end
`endif

    // State register
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Winner's transaction is frozen at grant so the requester's later
    // changes (allowed only after its ack) cannot disturb the access.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            gnt_q     <= GNT_CPU;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state_q == IDLE && any_req) begin
            gnt_q     <= gnt_sel;
            lat_we    <= (gnt_sel == GNT_DMA) ? dma_we    : cpu_we;
            lat_addr  <= (gnt_sel == GNT_DMA) ? dma_addr  : cpu_addr;
            lat_wdata <= (gnt_sel == GNT_DMA) ? dma_wdata : cpu_wdata;
        end
    end

    // Response registers: updated at the edge ending ACCESS, only for the winner.
    // A valid write leaves rdata alone; a fault forces rdata to 0.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cpu_rdata_q <= '0;
            cpu_err_q   <= 1'b0;
            dma_rdata_q <= '0;
            dma_err_q   <= 1'b0;
        end else if (state_q == ACCESS) begin
            if (gnt_q == GNT_CPU) begin
                cpu_err_q <= !addr_ok;
                if (!addr_ok) begin
                    cpu_rdata_q <= '0;
                end else if (!lat_we) begin
                    cpu_rdata_q <= mem_rdata;
                end
            end else begin
                dma_err_q <= !addr_ok;
                if (!addr_ok) begin
                    dma_rdata_q <= '0;
                end else if (!lat_we) begin
                    dma_rdata_q <= mem_rdata;
                end
            end
        end
    end

    // Outputs decoded from state; an async reset drops mem_wena at once
    // because the state register is forced to IDLE.
    always_comb begin
        mem_wena  = 1'b0;
        mem_rena  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_ack   = 1'b0;
        dma_ack   = 1'b0;
        case (state_q)
            ACCESS: begin
                if (addr_ok) begin
                    mem_wena  = lat_we;
                    mem_rena  = !lat_we;
                    mem_addr  = word_idx;
                    mem_wdata = lat_wdata;
                end
            end
            RESP: begin
                cpu_ack = (gnt_q == GNT_CPU);
                dma_ack = (gnt_q == GNT_DMA);
            end
            default: ;
        endcase
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_err   = cpu_err_q;
    assign dma_rdata = dma_rdata_q;
    assign dma_err   = dma_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed plan steps followed by randomized traffic.
// Latency: n/a (bench).
// Backpressure: requesters hold req until their ack, as a real master would.
module tb_dmem_arbiter;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        cpu_ack, cpu_err, dma_ack, dma_err;
    logic        mem_wena, mem_rena;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    // Environment memory seen by the DUT
    logic [31:0] dmem [0:2047];
    assign mem_rdata = dmem[mem_addr];
    always @(posedge clk_in) if (mem_wena) dmem[mem_addr] <= mem_wdata;

    int cyc = 0;
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    dmem_arbiter dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_err   (cpu_err),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_rdata (dma_rdata),
        .dma_ack   (dma_ack),
        .dma_err   (dma_err),
        .mem_wena  (mem_wena),
        .mem_rena  (mem_rena),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Reference model: memory contents, per-master response registers, last grant
    logic [31:0] ref_mem [0:2047];
    logic [31:0] exp_rd  [0:1];
    logic        exp_err [0:1];
    bit          last_dma;

    int n_chk  = 0;
    int n_pass = 0;

    // Observations recorded during serve_one for plan-level checks
    int          cpu_ack_cyc;
    int          prev_cpu_ack_cyc;
    logic        obs_dma_won;
    logic [31:0] obs_acc_addr;
    logic        obs_acc_wena;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Window membership computed as a plain range test on the byte address
    function automatic bit addr_ok_m(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off >= 0) && (off < 8192) && ((off % 4) == 0);
    endfunction

    function automatic int idx_m(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0, 1, 2: a = BASE + 4 * $urandom_range(0, 31);
            3, 4:    a = BASE + 4 * $urandom_range(0, 2047);
            5:       a = 32'h1001_1FFC;
            6:       a = 32'h1001_2000 + 4 * $urandom_range(0, 15);
            7:       a = 32'h1000_FFFC;
            8:       a = BASE + 4 * $urandom_range(0, 2047) + $urandom_range(1, 3);
            default: a = $urandom;
        endcase
        return a;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_wena"}, mem_wena, 0);
        chk({tag, "_rena"}, mem_rena, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdat"}, mem_wdata, 0);
        chk({tag, "_acks"}, {cpu_ack, dma_ack}, 0);
    endtask

    // Serve exactly one pending transaction. Entered just after an IDLE-cycle
    // edge with requests set up; leaves one edge after the ack cycle, with
    // the winner's req dropped.
    task automatic serve_one();
        bit          w;
        bit          we, v;
        logic [31:0] a, wd;
        int          idx;
        if (cpu_req && dma_req) begin
`ifdef DMEM_ARB_RR_EN
            w = !last_dma;
`else
            w = 1'b0;
`endif
        end else begin
            w = dma_req;
        end
        we  = w ? dma_we    : cpu_we;
        a   = w ? dma_addr  : cpu_addr;
        wd  = w ? dma_wdata : cpu_wdata;
        v   = addr_ok_m(a);
        idx = v ? idx_m(a) : 0;

        tick();  // ACCESS
        chk("acc_wena", mem_wena, v & we);
        chk("acc_rena", mem_rena, v & !we);
        chk("acc_addr", mem_addr, v ? idx : 0);
        chk("acc_wdat", mem_wdata, v ? wd : 32'h0);
        chk("acc_acks", {cpu_ack, dma_ack}, 0);
        obs_acc_addr = 32'(mem_addr);
        obs_acc_wena = mem_wena;

        if (!v) begin
            exp_rd[w]  = 32'h0;
            exp_err[w] = 1'b1;
        end else if (we) begin
            exp_err[w]   = 1'b0;
            ref_mem[idx] = wd;
        end else begin
            exp_err[w] = 1'b0;
            exp_rd[w]  = ref_mem[idx];
        end
        last_dma = w;

        tick();  // RESP
        chk("rsp_cack", cpu_ack, !w);
        chk("rsp_dack", dma_ack, w);
        chk("rsp_crd",  cpu_rdata, exp_rd[0]);
        chk("rsp_cerr", cpu_err, exp_err[0]);
        chk("rsp_drd",  dma_rdata, exp_rd[1]);
        chk("rsp_derr", dma_err, exp_err[1]);
        chk("rsp_mem",  {mem_wena, mem_rena}, 0);
        obs_dma_won = dma_ack;
        if (cpu_ack) begin
            prev_cpu_ack_cyc = cpu_ack_cyc;
            cpu_ack_cyc      = cyc;
        end

        tick();  // IDLE
        chk_quiet("idle");
        if (w) dma_req = 1'b0;
        else   cpu_req = 1'b0;
    endtask

    initial begin
        logic [31:0] v32;

        reset   = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        for (int i = 0; i < 2048; i++) begin
            v32        = $urandom;
            dmem[i]   <= v32;
            ref_mem[i] = v32;
        end
        exp_rd[0] = '0; exp_rd[1] = '0; exp_err[0] = 1'b0; exp_err[1] = 1'b0;
        last_dma    = 1'b1;
        cpu_ack_cyc = 0; prev_cpu_ack_cyc = 0;

        // Reset state
        #1;
        chk_quiet("rst");
        chk("rst_crd",  cpu_rdata, 0);
        chk("rst_cerr", cpu_err, 0);
        chk("rst_drd",  dma_rdata, 0);
        chk("rst_derr", dma_err, 0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // CPU write then read of 0x10010010
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1001_0010; cpu_wdata = 32'hDEAD_BEEF;
        serve_one();
        chk("plan_w_idx",  obs_acc_addr, 4);
        chk("plan_w_wena", obs_acc_wena, 1);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1001_0010; cpu_wdata = 32'h0;
        serve_one();
        chk("plan_rd",  cpu_rdata, 32'hDEAD_BEEF);
        chk("plan_err", cpu_err, 0);

        // Tie, then CPU re-requests while DMA is still pending
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = BASE + 32'h20;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = BASE + 32'h40;
        serve_one();
        chk("tie1_cpu", obs_dma_won, 0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = BASE + 32'h24;
        serve_one();
`ifdef DMEM_ARB_RR_EN
        chk("tie2_dma", obs_dma_won, 1);
`else
        chk("tie2_cpu", obs_dma_won, 0);
`endif
        while (cpu_req || dma_req) serve_one();

        // DMA faults: past the window, misaligned write, below the base
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h1001_2000;
        serve_one();
        chk("flt_hi_err", dma_err, 1);
        chk("flt_hi_rd",  dma_rdata, 0);
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h1001_0002; dma_wdata = 32'h1234_5678;
        serve_one();
        chk("flt_mis_err", dma_err, 1);
        chk("flt_mis_wen", obs_acc_wena, 0);
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h1000_FFFC;
        serve_one();
        chk("flt_lo_err", dma_err, 1);

        // Last valid word
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1001_1FFC;
        serve_one();
        chk("bnd_idx", obs_acc_addr, 2047);
        chk("bnd_err", cpu_err, 0);

        // Back-to-back CPU reads: acks exactly 3 cycles apart
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = BASE + 32'h100;
        serve_one();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = BASE + 32'h104;
        serve_one();
        chk("b2b_gap", cpu_ack_cyc - prev_cpu_ack_cyc, 3);

        // Reset in the middle of a write's ACCESS cycle
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1001_0010; cpu_wdata = 32'hCAFE_F00D;
        tick();
        chk("arst_pre_wena", mem_wena, 1);
        #2 reset = 1'b0;
        #1;
        chk_quiet("arst");
        chk("arst_crd", cpu_rdata, 0);
        chk("arst_drd", dma_rdata, 0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0; exp_err[0] = 1'b0; exp_err[1] = 1'b0;
        last_dma = 1'b1;
        tick();
        chk_quiet("arst_hold");
        reset = 1'b1;
        tick();
        chk("arst_noack", {cpu_ack, dma_ack}, 0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1001_0010;
        serve_one();
        chk("arst_old", cpu_rdata, 32'hDEAD_BEEF);

        // Randomized traffic from both masters
        for (int i = 0; i < 300; i++) begin
            if (!cpu_req && ($urandom_range(0, 1) == 1)) begin
                cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = pick_addr(); cpu_wdata = $urandom;
            end
            if (!dma_req && ($urandom_range(0, 2) == 0)) begin
                dma_req = 1'b1; dma_we = 1'($urandom_range(0, 1));
                dma_addr = pick_addr(); dma_wdata = $urandom;
            end
            if (cpu_req || dma_req) begin
                serve_one();
            end else begin
                tick();
                chk_quiet("rnd_idle");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
